// File: rtl/tx_ep_arbiter_pkg.sv
// Shared definitions for the endpoint transmit-interface arbiter: FSM encoding,
// requester count limit and the fixed requester slot assignment.
package tx_ep_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_OWNED    = 2'd2
  } arb_state_e;

  localparam int N_REQ_MAX = 8;

  // Requester slots on the req_ep / my_turn / driving_interface vectors.
  localparam int REQ_INTR  = 0;
  localparam int REQ_RXDMA = 1;
  localparam int REQ_TXDMA = 2;
  localparam int REQ_CPL   = 3;

endpackage

// File: rtl/tx_ep_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit found searching
// ptr, ptr+1, ... modulo N_REQ.
module tx_ep_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest slot back toward ptr so the nearest request wins.
  always_comb begin
    valid  = |req;
    winner = '0;
    idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IDX_W'((int'(ptr) + i) % N_REQ);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/tx_ep_arbiter.sv
// Round-robin owner of the PCIe endpoint TX interface: grants one requester at
// a time, waits for it to take the interface, and holds until it lets go.
module tx_ep_arbiter
  import tx_ep_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                     trn_clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_ep,
  input  logic [N_REQ-1:0]         driving_interface,
  output logic [N_REQ-1:0]         my_turn,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     arb_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  arb_state_e       state, state_next;
  logic [IDX_W-1:0] ptr, ptr_next, grant_next, winner;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [N_REQ-1:0] turn_next, owner_mask;
  logic             pick_valid, intruder, err_next;

  tx_ep_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req_ep),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (winner)
  );

  assign owner_mask = N_REQ'(1) << grant_id;
  assign busy       = (state != ST_IDLE);

  always_comb begin
    // NOTE: every signal driven here is defaulted first, so no path can infer a latch.
    state_next = state;
    ptr_next   = ptr;
    grant_next = grant_id;
    cnt_next   = cnt;
    turn_next  = '0;
    intruder   = (state == ST_IDLE) ? |driving_interface
                                    : |(driving_interface & ~owner_mask);
    err_next   = intruder;

    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          turn_next  = N_REQ'(1) << winner;
          grant_next = winner;
          ptr_next   = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
          cnt_next   = '0;
          state_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (driving_interface[grant_id]) begin
          state_next = ST_OWNED;
        end else begin
          cnt_next = cnt + CNT_W'(1);
          // Give up on a silent grantee; ptr has already moved past it.
          if (cnt_next == CNT_W'(ACK_TIMEOUT)) begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_OWNED: begin
        if (!driving_interface[grant_id]) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge trn_clk) begin
    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      grant_id <= '0;
      cnt      <= '0;
      my_turn  <= '0;
      arb_err  <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      grant_id <= grant_next;
      cnt      <= cnt_next;
      my_turn  <= turn_next;
      arb_err  <= err_next;
    end
  end

endmodule

// File: tb/tb_tx_ep_arbiter.sv
// Randomised and directed bench for tx_ep_arbiter: requester agents drive the
// handshake and a cycle-indexed reference model predicts every output.
module tb_tx_ep_arbiter;
  import tx_ep_arbiter_pkg::*;

  localparam int N = 4;
  localparam int T = 16;

  logic                 trn_clk = 1'b0;
  logic                 reset = 1'b1;
  logic [N-1:0]         req_ep = '0;
  logic [N-1:0]         driving_interface = '0;
  logic [N-1:0]         my_turn;
  logic [$clog2(N)-1:0] grant_id;
  logic                 busy;
  logic                 arb_err;

  always #5 trn_clk = ~trn_clk;

  tx_ep_arbiter #(.N_REQ(N), .ACK_TIMEOUT(T)) dut (
    .trn_clk           (trn_clk),
    .reset             (reset),
    .req_ep            (req_ep),
    .driving_interface (driving_interface),
    .my_turn           (my_turn),
    .grant_id          (grant_id),
    .busy              (busy),
    .arb_err           (arb_err)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // Requester agents
  logic [N-1:0] own_drv = '0, pend = '0, dead_mask = '0, inj = '0, inj_next = '0;
  int  hold_left[N];
  int  hold_len[N];
  bit  rand_mode = 1'b0;
  int  err_seen = 0, last_err_cyc = 0;
  int  gq[$];
  int  gcq[$];

  // Reference model: mode 0 = nobody granted, 1 = granted awaiting takeover, 2 = owned
  int           m_mode = 0, m_ptr = 0, m_gid = 0, m_grant_cyc = 0;
  logic [N-1:0] e_turn = '0;
  int           e_gid = 0;
  bit           e_busy = 1'b0, e_err = 1'b0;

  int exp_s2[5] = '{0, 1, 2, 3, 0};
  int exp_s6[3] = '{3, 0, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    logic [N-1:0] om;
    int w;
    e_turn = '0;
    e_err  = 1'b0;
    if (reset) begin
      m_mode = 0; m_ptr = 0; m_gid = 0;
    end else begin
      om = '0;
      om[m_gid] = 1'b1;
      e_err = (m_mode == 0) ? |driving_interface : |(driving_interface & ~om);
      if (m_mode == 0) begin
        w = rr_winner(req_ep, m_ptr);
        if (w >= 0) begin
          e_turn[w]   = 1'b1;
          m_gid       = w;
          m_ptr       = (w + 1) % N;
          m_grant_cyc = cyc + 1;
          m_mode      = 1;
        end
      end else if (m_mode == 1) begin
        if (driving_interface[m_gid]) m_mode = 2;
        else if (cyc + 1 - m_grant_cyc == T) begin
          e_err  = 1'b1;
          m_mode = 0;
        end
      end else begin
        if (!driving_interface[m_gid]) m_mode = 0;
      end
    end
    e_gid  = m_gid;
    e_busy = (m_mode != 0);
  endtask

  // One cycle: agents set this cycle's inputs, model predicts, then outputs are checked.
  task automatic step();
    if (reset) begin
      req_ep = '0; own_drv = '0; pend = '0; inj = '0;
    end else begin
      inj = inj_next;
      inj_next = '0;
      if (rand_mode && $urandom_range(0, 15) == 0) begin
        inj = '0;
        inj[$urandom_range(0, N - 1)] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          pend[i] = 1'b0;
          if (!dead_mask[i]) begin
            own_drv[i]   = 1'b1;
            hold_left[i] = hold_len[i];
          end
        end else if (own_drv[i]) begin
          hold_left[i]--;
          if (hold_left[i] <= 0) own_drv[i] = 1'b0;
        end
        if (my_turn[i]) begin
          pend[i]   = 1'b1;
          req_ep[i] = 1'b0;
          if (rand_mode) begin
            hold_len[i]  = $urandom_range(1, 12);
            dead_mask[i] = ($urandom_range(0, 9) == 0);
          end
        end
        if (rand_mode && !req_ep[i] && $urandom_range(0, 5) == 0) req_ep[i] = 1'b1;
      end
    end
    driving_interface = own_drv | inj;
    model_step();
    @(negedge trn_clk);
    cyc++;
    check("my_turn", my_turn, e_turn);
    check("grant_id", grant_id, e_gid);
    check("busy", busy, e_busy);
    check("arb_err", arb_err, e_err);
    for (int k = 0; k < N; k++)
      if (my_turn[k]) begin
        gq.push_back(k);
        gcq.push_back(cyc);
      end
    if (arb_err) begin
      err_seen++;
      last_err_cyc = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_grants(input int n, input int budget, input string tag);
    int b = 0;
    while (gq.size() < n && b < budget) begin
      step();
      b++;
    end
    check({tag, "_grant_budget"}, gq.size() >= n, 1);
  endtask

  task automatic wait_owned(input int i, input int budget, input string tag);
    int b = 0;
    while (!own_drv[i] && b < budget) begin
      step();
      b++;
    end
    check({tag, "_own_budget"}, own_drv[i], 1);
  endtask

  task automatic clear_logs();
    gq.delete();
    gcq.delete();
    err_seen = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      hold_len[i]  = 3;
      hold_left[i] = 0;
    end
    @(negedge trn_clk);
    check("reset_my_turn", my_turn, 0);
    check("reset_grant_id", grant_id, 0);
    check("reset_busy", busy, 0);
    check("reset_arb_err", arb_err, 0);
    run(2);
    reset = 1'b0;

    // Single requester holding the interface for 10 cycles
    clear_logs();
    hold_len[REQ_INTR] = 10;
    req_ep[REQ_INTR] = 1'b1;
    run(20);
    check("s1_grants", gq.size(), 1);
    check("s1_busy", busy, 0);
    check("s1_grant_id", grant_id, REQ_INTR);

    // All four from reset: 0,1,2,3 then 0 again
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_logs();
    for (int i = 0; i < N; i++) hold_len[i] = 3;
    req_ep = '1;
    wait_grants(4, 100, "s2a");
    req_ep[REQ_INTR] = 1'b1;
    wait_grants(5, 100, "s2b");
    for (int k = 0; k < 5; k++)
      check("s2_order", (gq.size() > k) ? gq[k] : -1, exp_s2[k]);
    run(12);

    // Requester 2 never takes the interface
    clear_logs();
    dead_mask = 4'b0100;
    req_ep = 4'b1100;
    wait_grants(2, 100, "s3");
    run(10);
    dead_mask = '0;
    check("s3_first", (gq.size() > 0) ? gq[0] : -1, REQ_TXDMA);
    check("s3_next", (gq.size() > 1) ? gq[1] : -1, REQ_CPL);
    check("s3_err_count", err_seen, 1);
    check("s3_timeout_gap", (gcq.size() > 0) ? last_err_cyc - gcq[0] : -1, T);

    // Requester 1 drives while 0 owns
    clear_logs();
    hold_len[REQ_INTR] = 10;
    req_ep = 4'b0001;
    wait_owned(REQ_INTR, 20, "s4");
    run(2);
    inj_next = 4'b0010;
    run(3);
    check("s4_err_count", err_seen, 1);
    check("s4_grant_id", grant_id, REQ_INTR);
    check("s4_busy", busy, 1);
    run(12);

    // Reset while owned, then full request set starts from requester 0
    hold_len[REQ_RXDMA] = 20;
    req_ep = 4'b0010;
    wait_owned(REQ_RXDMA, 20, "s5");
    run(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("s5_busy", busy, 0);
    check("s5_grant_id", grant_id, 0);
    clear_logs();
    for (int i = 0; i < N; i++) hold_len[i] = 2;
    req_ep = '1;
    wait_grants(4, 100, "s5");
    check("s5_first", (gq.size() > 0) ? gq[0] : -1, REQ_INTR);
    run(10);

    // Owner 3 re-requests while owning; 0 also waiting
    clear_logs();
    hold_len[REQ_CPL] = 6;
    req_ep = 4'b1000;
    wait_owned(REQ_CPL, 20, "s6");
    req_ep = 4'b1001;
    wait_grants(3, 100, "s6");
    for (int k = 0; k < 3; k++)
      check("s6_order", (gq.size() > k) ? gq[k] : -1, exp_s6[k]);
    run(15);

    // Random traffic with dead grantees, intruders and occasional reset
    rand_mode = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 399) == 0) reset = 1'b1;
      step();
      reset = 1'b0;
    end
    rand_mode = 1'b0;
    dead_mask = '0;
    req_ep = '0;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
